// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: picks one writer per cycle for the register file write port.
// Sources: in-order pipeline writebacks and long-latency results buffered in a
// 2-entry FIFO. A starvation counter raises stall_req_o so buffered results
// cannot be locked out by a pipeline that writes every cycle.
// Optional feature macro: WB_LL_BYPASS_EN (an LL result arriving while the FIFO
// is empty and the port is free is written directly, one cycle earlier).
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_we_i,
    input  logic [ADDR_W-1:0] p_waddr_i,
    input  logic [DATA_W-1:0] p_wdata_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              ll_valid_i,
    output logic              ll_ready_o,
    input  logic [ADDR_W-1:0] ll_waddr_i,
    input  logic [DATA_W-1:0] ll_wdata_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              ll_pending_o,
    output logic              stall_req_o
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    // FIFO storage and control
    logic [1:0][ADDR_W-1:0] addr_mem_q, addr_mem_d;
    logic [1:0][DATA_W-1:0] data_mem_q, data_mem_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             count_q, count_d;

    // Starvation tracking
    logic [SW-1:0]          starve_q, starve_d;
    logic                   stall_req_q, stall_req_d;

    // Registered write port
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      waddr_q, waddr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;

    logic p_eff, fifo_ne, ll_xfer, ll_keep, enq, deq;

    // Ready depends only on registered occupancy; no same-cycle drain look-ahead.
    assign ll_ready_o   = (count_q < 2'd2);
    assign ll_pending_o = (count_q != 2'd0);
    assign stall_req_o  = stall_req_q;
    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;

    assign fifo_ne = (count_q != 2'd0);
    assign ll_xfer = ll_valid_i & ll_ready_o;
    // r0 results are consumed by the handshake but never written.
    assign ll_keep = ll_xfer & (ll_waddr_i != '0);
    // Pipeline writes to r0 are bubbles; the port stays free for the FIFO.
    assign p_eff   = p_we_i & ~stall_i & ~flush_i & ~stall_req_q & (p_waddr_i != '0);

    // Port arbitration, FIFO bookkeeping and starvation counter next state.
    always_comb begin
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        deq        = 1'b0;
        enq        = ll_keep;
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;

        // Forced drain beats the pipeline; p_eff is already masked by stall_req.
        if (fifo_ne && stall_req_q) begin
            deq = 1'b1;
        end else if (p_eff) begin
            we_d    = 1'b1;
            waddr_d = p_waddr_i;
            wdata_d = p_wdata_i;
        end else if (fifo_ne) begin
            deq = 1'b1;
        end else begin
`ifdef WB_LL_BYPASS_EN
            // Empty FIFO and idle port: skip the buffer entirely.
            if (ll_keep) begin
                we_d    = 1'b1;
                waddr_d = ll_waddr_i;
                wdata_d = ll_wdata_i;
                enq     = 1'b0;
            end
`endif
        end

        if (deq) begin
            we_d    = 1'b1;
            waddr_d = addr_mem_q[rd_ptr_q];
            wdata_d = data_mem_q[rd_ptr_q];
        end

        if (enq) begin
            addr_mem_d[wr_ptr_q] = ll_waddr_i;
            data_mem_d[wr_ptr_q] = ll_wdata_i;
        end

        wr_ptr_d = wr_ptr_q ^ enq;
        rd_ptr_d = rd_ptr_q ^ deq;
        count_d  = count_q + {1'b0, enq} - {1'b0, deq};

        // Count cycles a buffered result loses the port to the pipeline.
        if (!fifo_ne || deq) begin
            starve_d = '0;
        end else if (p_eff && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end
        // Registered so it asserts the cycle the counter reaches its limit.
        stall_req_d = (starve_d == STARVE_LIM);
    end

    // State registers; synchronous reset drops all buffered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_mem_q  <= '0;
            data_mem_q  <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            starve_q    <= '0;
            stall_req_q <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            addr_mem_q  <= addr_mem_d;
            data_mem_q  <= data_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            stall_req_q <= stall_req_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Writeback arbiter sitting between the MEM/WB pipeline stage, the long-latency units (divider, load-miss return) and the single write port of the general-purpose register file. It accepts in-order pipeline writebacks plus out-of-band long-latency results over a valid/ready handshake. It buffers the long-latency results in a 2-entry FIFO and drives one registered write per cycle onto the regfile write port. It raises a stall request when buffered results are starved of the port.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (32 registers)
- STARVE_MAX, 4, consecutive starved cycles before stall request

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- p_we_i  in  1  pipeline writeback valid
- p_waddr_i  in  ADDR_W  pipeline destination register
- p_wdata_i  in  DATA_W  pipeline result
- stall_i  in  1  pipeline stalled; pipeline input ignored this cycle
- flush_i  in  1  pipeline flushed; pipeline input ignored this cycle
- ll_valid_i  in  1  long-latency result valid
- ll_ready_o  out  1  FIFO can accept
- ll_waddr_i  in  ADDR_W  long-latency destination register
- ll_wdata_i  in  DATA_W  long-latency result
- we_o  out  1  regfile write enable
- waddr_o  out  ADDR_W  regfile write address
- wdata_o  out  DATA_W  regfile write data
- ll_pending_o  out  1  FIFO non-empty
- stall_req_o  out  1  request pipeline bubble to drain FIFO

## Operation
- Pipeline request is effective when p_we_i=1, stall_i=0, flush_i=0, stall_req_o=0 and p_waddr_i≠0.
- Each cycle exactly one write source is chosen, in this priority order:
  1. FIFO head, if stall_req_o=1.
  2. Effective pipeline request.
  3. FIFO head, if non-empty.
  4. No write.
- The chosen write is registered onto we_o/waddr_o/wdata_o. With no write, we_o=0; waddr_o and wdata_o hold their previous values.
- Pipeline request with p_waddr_i=0 is a bubble. The port counts as free that cycle.
- LL handshake: a transfer occurs when ll_valid_i=1 and ll_ready_o=1.
  - ll_ready_o = (count<2). It is a function of registered count only; it does not look ahead to a same-cycle drain.
  - A transfer with ll_waddr_i=0 is accepted and discarded (not enqueued).
- FIFO: 2 entries, pointer wrap mod 2, count 0..2. Simultaneous enqueue and dequeue keeps count unchanged, FIFO order preserved.
- Starvation counter (0..STARVE_MAX):
  - Increments each cycle the FIFO is non-empty and the pipeline wins the port.
  - Clears on any dequeue or when the FIFO is empty.
  - stall_req_o is registered and equals (counter==STARVE_MAX). It forces exactly one drain, after which the counter clears.
- The pipeline input ignored under stall_req_o=1 must be held by the pipeline controller, which maps stall_req_o into stall_i. The block does not store it.
- No reordering or WAW checking: the hazard unit guarantees a destination register has at most one outstanding writer.

## Timing
- Reset values: we_o=0, waddr_o=0, wdata_o=0, ll_ready_o=1, ll_pending_o=0, stall_req_o=0, FIFO count=0, starvation counter=0.
- Pipeline latency: effective request at cycle N gives we_o=1 at N+1.
- LL latency, port free: accepted at N, written at N+2 (N+1 with bypass, see Configuration).
- ll_pending_o reflects registered count.
- rst mid-operation:
  - All buffered LL results are dropped.
  - we_o=0 on the cycle after rst is sampled.
  - An LL transfer in the reset cycle is lost.

## Configuration
- WB_LL_BYPASS_EN:
  - Defined: when the FIFO is empty, the port is free, and an LL transfer with nonzero address occurs at cycle N, the result is written at N+1 directly and not enqueued.
  - Undefined: every LL result passes through the FIFO (minimum latency 2). All other behaviour is identical.

## Test plan
- Pipeline write r3=0x12345678 at cycle 1 -> we_o=1, waddr_o=3, wdata_o=0x12345678 at cycle 2; pipeline write to r0 -> we_o=0.
- LL r7=0xDEADBEEF with pipeline idle -> write at +2 cycles (+1 with WB_LL_BYPASS_EN); ll_pending_o high exactly while buffered.
- Two LL transfers, r8=0x8 then r9=0x9, while the pipeline writes every cycle -> ll_ready_o drops to 0 after the second. After 4 starved cycles stall_req_o=1, then r8 is written; one cycle later stall_req_o=0.
- FIFO full with simultaneous dequeue and ll_valid_i=1 -> no transfer that cycle (ll_ready_o=0); transfer succeeds the next cycle; order r8, r9, r10 preserved.
- flush_i=1 with p_we_i=1, p_waddr_i=5 -> no write to r5; a FIFO entry, if present, drains that cycle.
- rst asserted with 2 entries buffered and we_o=1 -> next cycle we_o=0, ll_pending_o=0, ll_ready_o=1; the buffered entries are never written.
